// File: rtl/mem_group.sv
// mem_group: single-port word-addressed RAM with four byte-lane banks,
// byte-masked writes and a registered, read-first read port.
`default_nettype none

module mem_group #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH/8-1:0] write_mask,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH-1:0]   read_data
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    // Both updates are non-blocking, so the read sees the pre-write byte
    // (read-first). Writes share the reset branch so reset also blocks them.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= 8'h00;
      end else begin
        rd_q <= mem_q[addr];
        if (write_mask[i]) begin
          mem_q[addr] <= write_data[8*i +: 8];
        end
      end
    end

    assign read_data[8*i +: 8] = rd_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_group.sv
// Directed self-checking bench for mem_group.
`default_nettype none

module tb_mem_group;

  logic        clk;
  logic        rst_n;
  logic [3:0]  write_mask;
  logic [13:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_mem [0:5];

  mem_group #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_mask (write_mask),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one access, let it be captured at the next rising edge, and return
  // 1 time unit after that edge so read_data can be sampled.
  task automatic cyc(input logic [3:0] m, input logic [13:0] a, input logic [31:0] d);
    write_mask = m;
    addr       = a;
    write_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_value: read_data=%h expected=%h", read_data, 32'h0);
    end
  endtask

  task automatic test_full_write;
    for (int k = 1; k <= 5; k++) begin
      exp_mem[k] = 32'h1000_0000 * k + 32'h0000_0101 * k;
      cyc(4'b1111, 14'(k), exp_mem[k]);
    end
    cyc(4'b1111, 14'd0, 32'h77ff8855);
    exp_mem[0] = 32'h77ff8855;
    cyc(4'b0000, 14'd0, 32'h0);
    checks++;
    if (read_data !== 32'h77ff8855) begin
      errors++;
      $display("FAIL full_readback: read_data=%h expected=%h", read_data, 32'h77ff8855);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(4'b0000, 14'(k), 32'hFFFF_FFFF);
      checks++;
      if (read_data !== exp_mem[k]) begin
        errors++;
        $display("FAIL neighbour_%0d: read_data=%h expected=%h", k, read_data, exp_mem[k]);
      end
    end
  endtask

  task automatic test_byte_lanes;
    cyc(4'b0101, 14'd0, 32'hAABBCCDD);
    cyc(4'b0000, 14'd0, 32'h0);
    checks++;
    if (read_data !== 32'h77BB88DD) begin
      errors++;
      $display("FAIL lanes_0101: read_data=%h expected=%h", read_data, 32'h77BB88DD);
    end
    cyc(4'b1010, 14'd0, 32'h11223344);
    cyc(4'b0000, 14'd0, 32'h0);
    checks++;
    if (read_data !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL lanes_1010: read_data=%h expected=%h", read_data, 32'h11BB33DD);
    end
    exp_mem[0] = 32'h11BB33DD;
  endtask

  task automatic test_read_first;
    cyc(4'b1111, 14'd5, 32'h12345678);
    cyc(4'b1111, 14'd5, 32'hCAFEBABE);
    checks++;
    if (read_data !== 32'h12345678) begin
      errors++;
      $display("FAIL read_first_old: read_data=%h expected=%h", read_data, 32'h12345678);
    end
    cyc(4'b0000, 14'd5, 32'h0);
    checks++;
    if (read_data !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL read_first_new: read_data=%h expected=%h", read_data, 32'hCAFEBABE);
    end
    exp_mem[5] = 32'hCAFEBABE;
  endtask

  task automatic test_addr_extremes;
    cyc(4'b1111, 14'h3FFF, 32'hDEADBEEF);
    cyc(4'b1111, 14'h0000, 32'h01020304);
    cyc(4'b0000, 14'h3FFF, 32'h0);
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL addr_top: read_data=%h expected=%h", read_data, 32'hDEADBEEF);
    end
    cyc(4'b0000, 14'h0000, 32'h0);
    checks++;
    if (read_data !== 32'h01020304) begin
      errors++;
      $display("FAIL addr_bottom: read_data=%h expected=%h", read_data, 32'h01020304);
    end
  endtask

  task automatic test_reset_midcycle;
    cyc(4'b1111, 14'd0, 32'h77ff8855);
    cyc(4'b0000, 14'd0, 32'h0);
    exp_mem[0] = 32'h77ff8855;
    checks++;
    if (read_data !== 32'h77ff8855) begin
      errors++;
      $display("FAIL pre_reset_read: read_data=%h expected=%h", read_data, 32'h77ff8855);
    end
    #2;
    rst_n      = 1'b0;
    write_mask = 4'b1111;
    write_data = 32'hFFFF_FFFF;
    addr       = 14'd0;
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_async_clear: read_data=%h expected=%h", read_data, 32'h0);
    end
    repeat (2) @(posedge clk);
    addr = 14'd1;
    @(posedge clk);
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: read_data=%h expected=%h", read_data, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0000, 14'd0, 32'h0);
    checks++;
    if (read_data !== 32'h77ff8855) begin
      errors++;
      $display("FAIL reset_no_write0: read_data=%h expected=%h", read_data, 32'h77ff8855);
    end
    cyc(4'b0000, 14'd1, 32'h0);
    checks++;
    if (read_data !== exp_mem[1]) begin
      errors++;
      $display("FAIL reset_no_write1: read_data=%h expected=%h", read_data, exp_mem[1]);
    end
  endtask

  task automatic test_mask_zero;
    for (int k = 0; k <= 4; k++) begin
      cyc(4'b0000, 14'(k), $urandom);
      checks++;
      if (read_data !== exp_mem[k]) begin
        errors++;
        $display("FAIL mask_zero_%0d: read_data=%h expected=%h", k, read_data, exp_mem[k]);
      end
    end
    cyc(4'b0000, 14'd5, 32'h0);
    checks++;
    if (read_data !== exp_mem[5]) begin
      errors++;
      $display("FAIL mask_zero_5: read_data=%h expected=%h", read_data, exp_mem[5]);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    write_mask = 4'b0000;
    addr       = 14'd0;
    write_data = 32'h0;
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_full_write;
    test_byte_lanes;
    test_read_first;
    test_addr_extremes;
    test_reset_midcycle;
    test_mask_zero;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: sim_time=%0t limit=%0d", $time, 100000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
